voice_mixer: RTL and testbench

- Sits directly downstream of the pipelined bank manager.
- Consumes its time-multiplexed 24-bit voice stream: one voice sample per clk_en cycle, NBANKS slots per frame.
- Sums each frame of NBANKS consecutive samples, applies a power-of-two gain, saturates to 24 bits and queues the mixed sample in a small FIFO.
- The audio output interface drains the FIFO through a valid/ready handshake.

---
 rtl/voice_mixer_if.sv | 10 +
 rtl/voice_mixer.sv | 118 +++++++++++
 tb/tb_voice_mixer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/voice_mixer_if.sv
// Mixed-sample output stream: registered head-of-FIFO sample with a valid/ready handshake.
// master = voice_mixer (producer), slave = audio output interface (consumer).
interface voice_mixer_if;
    logic signed [23:0] o_sample;
    logic               o_valid;
    logic               i_ready;

    modport master (output o_sample, output o_valid, input i_ready);
    modport slave  (input o_sample, input o_valid, output i_ready);
endinterface

// File: rtl/voice_mixer.sv
// Sums each NBANKS-slot frame of the bank manager's voice stream, scales by 2^-SHIFT,
// saturates to 24 bits and queues the result in a small FIFO drained over valid/ready.
module voice_mixer #(
    parameter int NBANKS     = 10,
    parameter int SHIFT      = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_en,
    input  logic signed [23:0]  i_signal,
    voice_mixer_if.master       o_stream,
    output logic                o_clip,
    output logic [7:0]          o_overrun_cnt
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [3:0]        LAST_SLOT = 4'(NBANKS - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic signed [27:0] SAT_MAX  = 28'sd8388607;
    localparam logic signed [27:0] SAT_MIN  = -28'sd8388608;

    logic [3:0]             r_slot;
    logic signed [27:0]     r_acc;
    logic [23:0]            r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;
    logic                   r_clip;
    logic [7:0]             r_overrun_cnt;

    logic signed [27:0]     w_sig_ext;
    logic signed [27:0]     w_sum;
    logic signed [27:0]     w_scaled;
    logic [23:0]            w_sat_val;
    logic                   w_sat;
    logic                   w_close;
    logic                   w_valid;
    logic                   w_full;
    logic                   w_do_pop;
    logic                   w_do_push;

    assign w_sig_ext = {{4{i_signal[23]}}, i_signal};
    assign w_sum     = r_acc + w_sig_ext;
    assign w_scaled  = w_sum >>> SHIFT;
    assign w_close   = clk_en && (r_slot == LAST_SLOT);

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        w_sat_val = w_scaled[23:0];
        w_sat     = 1'b0;
        if (w_scaled > SAT_MAX) begin
            w_sat_val = SAT_MAX[23:0];
            w_sat     = 1'b1;
        end else if (w_scaled < SAT_MIN) begin
            w_sat_val = SAT_MIN[23:0];
            w_sat     = 1'b1;
        end
    end

    assign w_valid   = (r_count != '0);
    assign w_full    = (r_count == FULL_CNT);
    assign w_do_pop  = w_valid && o_stream.i_ready;
    // A full FIFO still accepts the frame when the consumer frees a slot on the same edge.
    assign w_do_push = w_close && (!w_full || w_do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot        <= '0;
            r_acc         <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_clip        <= 1'b0;
            r_overrun_cnt <= '0;
        end else begin
            r_clip <= w_close && w_sat;
            if (clk_en) begin
                if (w_close) begin
                    r_slot <= '0;
                    r_acc  <= '0;
                end else begin
                    r_slot <= r_slot + 4'd1;
                    r_acc  <= w_sum;
                end
            end
            if (w_close && !w_do_push && (r_overrun_cnt != 8'hFF)) begin
                r_overrun_cnt <= r_overrun_cnt + 8'd1;
            end
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // NOTE: the storage array is not reset; r_count alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= w_sat_val;
        end
    end

    assign o_stream.o_valid  = w_valid;
    assign o_stream.o_sample = w_valid ? r_mem[r_rd_ptr] : '0;
    assign o_clip            = r_clip;
    assign o_overrun_cnt     = r_overrun_cnt;

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer: frame sums, saturation, clk_en gating, FIFO overrun,
// simultaneous push/pop when full and mid-frame reset, all against hand-computed values.
module tb_voice_mixer;

    logic               clk;
    logic               reset;
    logic               clk_en;
    logic signed [23:0] i_signal;
    logic               o_clip;
    logic [7:0]         o_overrun_cnt;

    int n_checks;
    int n_pass;

    voice_mixer_if u_if ();

    voice_mixer #(
        .NBANKS     (10),
        .SHIFT      (3),
        .FIFO_DEPTH (4)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .clk_en        (clk_en),
        .i_signal      (i_signal),
        .o_stream      (u_if),
        .o_clip        (o_clip),
        .o_overrun_cnt (o_overrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it, away from the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [23:0] v);
        clk_en   = 1'b1;
        i_signal = v;
        tick();
    endtask

    task automatic idle();
        clk_en   = 1'b0;
        i_signal = 24'sd0;
        tick();
    endtask

    task automatic send_frame(input logic signed [23:0] v);
        for (int i = 0; i < 10; i++) send(v);
    endtask

    function automatic logic signed [31:0] samp();
        return 32'(u_if.o_sample);
    endfunction

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        reset       = 1'b1;
        clk_en      = 1'b0;
        i_signal    = 24'sd0;
        u_if.i_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(u_if.o_valid), 0);
        check("rst_sample", samp(), 0);
        check("rst_clip", 32'(o_clip), 0);
        check("rst_ovr", 32'(o_overrun_cnt), 0);
        reset = 1'b0;

        // 10 x 800000 = 8000000 >>> 3 = 1000000, visible for exactly one cycle
        u_if.i_ready = 1'b1;
        for (int i = 0; i < 9; i++) send(24'sd800000);
        check("f1_pre_valid", 32'(u_if.o_valid), 0);
        send(24'sd800000);
        check("f1_valid", 32'(u_if.o_valid), 1);
        check("f1_sample", samp(), 1000000);
        check("f1_clip", 32'(o_clip), 0);
        idle();
        check("f1_popped", 32'(u_if.o_valid), 0);

        // positive saturation: 83886070 >>> 3 = 10485758 -> 8388607
        send_frame(24'sd8388607);
        check("satp_sample", samp(), 8388607);
        check("satp_clip", 32'(o_clip), 1);
        idle();
        check("satp_clip_end", 32'(o_clip), 0);

        // negative saturation: -83886080 >>> 3 = -10485760 -> -8388608
        send_frame(-24'sd8388608);
        check("satn_sample", samp(), -8388608);
        check("satn_clip", 32'(o_clip), 1);
        idle();
        check("satn_clip_end", 32'(o_clip), 0);

        // floor toward -inf: -1 >>> 3 = -1
        send(-24'sd1);
        for (int i = 0; i < 9; i++) send(24'sd0);
        check("floor_sample", samp(), -1);
        check("floor_clip", 32'(o_clip), 0);
        idle();

        // clk_en gating: disabled cycles carry 99999 and must be ignored; 80 >>> 3 = 10
        for (int i = 0; i < 9; i++) begin
            send(24'sd8);
            clk_en   = 1'b0;
            i_signal = 24'sd99999;
            tick();
            tick();
        end
        check("gate_pre_valid", 32'(u_if.o_valid), 0);
        send(24'sd8);
        check("gate_sample", samp(), 10);
        idle();

        // overrun: frames 10,20,30,40 fill the FIFO, 50 is dropped
        u_if.i_ready = 1'b0;
        for (int k = 1; k <= 5; k++) send_frame(24'(k * 8));
        idle();
        check("ovr_valid", 32'(u_if.o_valid), 1);
        check("ovr_head", samp(), 10);
        check("ovr_cnt", 32'(o_overrun_cnt), 1);
        u_if.i_ready = 1'b1;
        check("drain0", samp(), 10);
        idle();
        check("drain1", samp(), 20);
        idle();
        check("drain2", samp(), 30);
        idle();
        check("drain3", samp(), 40);
        idle();
        check("drain_valid", 32'(u_if.o_valid), 0);
        check("drain_sample", samp(), 0);

        // full FIFO with pop and push on the same edge: 50 accepted, no overrun
        u_if.i_ready = 1'b0;
        for (int k = 1; k <= 4; k++) send_frame(24'(k * 8));
        for (int i = 0; i < 9; i++) send(24'sd40);
        u_if.i_ready = 1'b1;
        send(24'sd40);
        check("pp_head", samp(), 20);
        check("pp_ovr", 32'(o_overrun_cnt), 1);
        idle();
        check("pp_d1", samp(), 30);
        idle();
        check("pp_d2", samp(), 40);
        idle();
        check("pp_d3", samp(), 50);
        idle();
        check("pp_empty", 32'(u_if.o_valid), 0);

        // mid-frame reset discards the partial sum and clears the overrun count
        for (int i = 0; i < 5; i++) send(24'sd1000);
        reset    = 1'b1;
        clk_en   = 1'b1;
        i_signal = 24'sd1000;
        tick();
        check("mrst_ovr", 32'(o_overrun_cnt), 0);
        check("mrst_valid", 32'(u_if.o_valid), 0);
        reset = 1'b0;
        for (int i = 0; i < 9; i++) send(24'sd8);
        check("mrst_pre_valid", 32'(u_if.o_valid), 0);
        send(24'sd8);
        check("mrst_sample", samp(), 10);
        idle();
        check("mrst_single", 32'(u_if.o_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
